data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
Parametrised data-memory unit between the RISC-V core's execute stage and a variable-latency data memory. It accepts one load or store per transaction, selected by read_en/write_en and Funct3. It generates byte enables and aligned write data, then waits for the memory acknowledge. Load data is sign- or zero-extended. Misaligned and timed-out accesses are reported. It replaces the fixed single-cycle load/store path with a handshake-based, width-generic block that stalls the core while a transaction is in flight.

Parameters:
WIDTH, 32, data width; legal values are 32 and 64.
ADDR_WIDTH, 32, byte-address width.
TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_ack before flagging timeout (≥2).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  core presents a load/store this cycle
req_ready  output  1  unit can accept a request (high only in IDLE)
read_en  input  1  load request
write_en  input  1  store request
Funct3  input  3  RISC-V funct3: [1:0] size (0=B,1=H,2=W,3=D), [2]=unsigned for loads
Mem_addr  input  ADDR_WIDTH  byte address
RS2_data  input  WIDTH  store data, right-aligned
dmu_out_data  output  WIDTH  extended load result
dmu_done  output  1  one-cycle pulse: transaction finished (ok or error)
stall  output  1  core must hold its pipeline
misalign_err  output  1  sticky until next accepted request
timeout_err  output  1  sticky until next accepted request
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1=write
mem_addr  output  ADDR_WIDTH  address aligned down to WIDTH/8 bytes
mem_be  output  WIDTH/8  byte enables
mem_wdata  output  WIDTH  lane-shifted store data
mem_rdata  input  WIDTH  read data, valid with mem_ack
mem_ack  input  1  memory completion, single-cycle pulse

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except req_ready=1. Timeout counter 0. Registered request fields cleared. A reset mid-transaction drops mem_req immediately and no dmu_done is issued.
- Acceptance: in IDLE, req_valid & (read_en ^ write_en) is accepted on the clock edge. Addr, Funct3, data and direction are captured, and the sticky errors are cleared.
  - req_valid with both enables or with neither: ignored (no state change, no done).
- stall = req_valid & (read_en|write_en) in IDLE (combinational), or any state other than IDLE.
- Illegal size (Funct3[1:0]=3 with WIDTH=32, or Funct3[2]=1 on a store): treated as misaligned.
- Alignment check on accept: offset = addr mod (WIDTH/8). Misaligned if offset is not a multiple of the access size. Result -> ERR.
- FSM:
  - IDLE -> REQ on an accepted aligned request; IDLE -> ERR if misaligned/illegal.
  - REQ: mem_req=1; mem_we, mem_addr, mem_be, mem_wdata stable from registers.
    - mem_ack -> RESP, and mem_rdata is captured.
    - counter reaches TIMEOUT_CYCLES with no ack -> ERR (timeout_err=1).
  - RESP (1 cycle): dmu_done=1. dmu_out_data updated for loads, unchanged for stores. -> IDLE.
  - ERR (1 cycle): dmu_done=1, the relevant sticky error set, mem_req=0, dmu_out_data unchanged. -> IDLE.
- Latency: accept edge, then mem_req high from the next cycle. An ack in the first REQ cycle gives done 2 cycles after accept. Minimum request-to-request spacing is 3 cycles.
- mem_ack outside REQ is ignored.
- Byte enables: size-wide mask of ones shifted left by offset.
- Write data: RS2_data replicated/shifted into lane offset*8.
- Load extraction: rdata >> (offset*8), masked to the size. Sign-extended from the top bit when Funct3[2]=0, zero-extended when 1. Full-width loads pass through unchanged.
- Timeout counter: reset on entry to REQ, saturating, width clog2(TIMEOUT_CYCLES+1).
- mem_ack arriving on the same cycle the counter hits the limit: ack wins (RESP).

Decomposition:
- Package dmu_pkg holds:
  - the state enum typedef (IDLE, REQ, RESP, ERR);
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - functions be_gen(size, offset) and load_extend(data, size, offset, uns).
- One sub-module, dmu_lane_align, is natural: purely combinational store shift/byte-enable plus load extract/extend. It is shared by the datapath and reused by the bench scoreboard.

Test Plan:
- Reset mid-REQ: accept LW @0x10, drop rst on the next cycle -> mem_req=0 same cycle, req_ready=1, no dmu_done, outputs 0.
- LB @0x0000_0003, Funct3=000, mem_rdata=0x80FF_1234, ack in first REQ cycle -> mem_be=4'b1000, dmu_out_data=0xFFFF_FF80, dmu_done 2 cycles after accept.
- SH @0x0000_0002, RS2_data=0x0000_ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata[31:16]=0xABCD; LHU from the same address with rdata=0xABCD_0000 -> 0x0000_ABCD.
- LW @0x0000_0006 -> no mem_req; ERR state; dmu_done and misalign_err=1 one cycle after accept; the error clears on the next accepted request.
- LW with mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles, then timeout_err=1 and dmu_done; a late ack after that is ignored.
- WIDTH=64: LD @0x8 -> mem_be=8'hFF. LW @0xC, Funct3=010, rdata=0x8000_0001_xxxx_xxxx -> dmu_out_data=0xFFFF_FFFF_8000_0001.

Source files
------------

// File: rtl/dmu_pkg.sv
// Shared types and helpers for the data-memory unit.
//   dmu_state_e  : transaction FSM states
//   SZ_*         : access-size encodings carried in funct3[1:0]
//   size_mask    : low-address bits that must be zero for an aligned access
//   be_gen       : byte-enable mask for a size at a byte offset (8-lane form)
//   load_extend  : extract a loaded field at a byte offset and sign/zero extend
// The helpers work on the widest (64-bit, 8-lane) form. Narrower users truncate
// the result, which is exact because an aligned access never crosses the word.
package dmu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } dmu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [2:0] size_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

  function automatic logic [7:0] be_gen(input logic [1:0] size,
                                        input logic [2:0] offset);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    m = m << offset;
    return m[7:0];
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] data,
                                              input logic [1:0]  size,
                                              input logic [2:0]  offset,
                                              input logic        uns);
    logic [63:0] s;
    logic [63:0] r;
    s = data >> {offset, 3'b000};
    case (size)
      SZ_B:    r = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      SZ_H:    r = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      SZ_W:    r = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmu_mem_if.sv
// Handshake bus between the data-memory unit and the data memory.
//   master (unit)  : drives mem_req/mem_we/mem_addr/mem_be/mem_wdata
//   slave (memory) : drives mem_rdata and the single-cycle mem_ack pulse
interface dmu_mem_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WIDTH/8-1:0]      mem_be;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH-1:0]        mem_rdata;
  logic                    mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dmu_lane_align.sv
// Combinational lane steering for the data-memory unit.
//   size, offset, uns : access size, byte offset inside the word, unsigned load
//   st_data           : right-aligned store data
//   ld_data           : raw memory read word
//   be                : byte enables for the access
//   wdata             : store data shifted into its byte lanes
//   ld_result         : extracted and extended load value
module dmu_lane_align
  import dmu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OFF_W = $clog2(WIDTH/8)
) (
  input  logic [1:0]         size,
  input  logic [OFF_W-1:0]   offset,
  input  logic               uns,
  input  logic [WIDTH-1:0]   st_data,
  input  logic [WIDTH-1:0]   ld_data,
  output logic [WIDTH/8-1:0] be,
  output logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   ld_result
);

  localparam int WB = WIDTH/8;

  assign be        = WB'(be_gen(size, 3'(offset)));
  assign wdata     = st_data << {offset, 3'b000};
  assign ld_result = WIDTH'(load_extend(64'(ld_data), size, 3'(offset), uns));

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory unit: accepts one load or store from the execute stage, issues it
// on a variable-latency memory handshake, and returns the extended load result.
//   clk, rst          : clock, asynchronous active-low reset
//   req_valid/ready   : core request handshake (ready only while idle)
//   read_en/write_en  : load / store select (exactly one must be set)
//   Funct3            : [1:0] size, [2] unsigned load
//   Mem_addr, RS2_data: byte address and right-aligned store data
//   dmu_out_data      : extended load result, held between loads
//   dmu_done          : one-cycle completion pulse (success or error)
//   stall             : core must hold its pipeline
//   misalign_err      : sticky, set for misaligned or illegal-size requests
//   timeout_err       : sticky, set when memory never acknowledged
//   mem               : memory bus (master side)
module data_mem_unit
  import dmu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [2:0]            Funct3,
  input  logic [ADDR_WIDTH-1:0] Mem_addr,
  input  logic [WIDTH-1:0]      RS2_data,
  output logic [WIDTH-1:0]      dmu_out_data,
  output logic                  dmu_done,
  output logic                  stall,
  output logic                  misalign_err,
  output logic                  timeout_err,
  dmu_mem_if.master             mem
);

  localparam int WB    = WIDTH/8;
  localparam int OFF_W = $clog2(WB);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);

  dmu_state_e state, state_d;

  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [2:0]            f3_p1;
  logic [WIDTH-1:0]      wdata_p1;
  logic                  we_p1;

  logic                  accept;
  logic                  bad_req;
  logic [1:0]            req_size;
  logic [OFF_W-1:0]      req_off;
  logic                  in_req;
  logic                  timeout_hit;

  logic [WB-1:0]         be_w;
  logic [WIDTH-1:0]      wdata_w;
  logic [WIDTH-1:0]      ld_w;

  // Request decode in IDLE: accept only a pure load or a pure store
  assign req_size = Funct3[1:0];
  assign req_off  = Mem_addr[OFF_W-1:0];
  assign accept   = (state == IDLE) && req_valid && (read_en ^ write_en);

  // Illegal sizes fold into the misaligned path
  assign bad_req  = ((WIDTH == 32) && (req_size == SZ_D)) ||
                    (write_en && Funct3[2]) ||
                    ((3'(req_off) & size_mask(req_size)) != 3'd0);

  assign in_req      = (state == REQ);
  // Ack in the last allowed cycle still wins over the timeout
  assign timeout_hit = in_req && !mem.mem_ack &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES-1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = bad_req ? ERR : REQ;
      REQ: begin
        if (mem.mem_ack)      state_d = RESP;
        else if (timeout_hit) state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: request fields captured on accept, control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_p1      <= '0;
      f3_p1        <= '0;
      wdata_p1     <= '0;
      we_p1        <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      dmu_out_data <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_p1      <= Mem_addr;
        f3_p1        <= Funct3;
        wdata_p1     <= RS2_data;
        we_p1        <= write_en;
        cnt          <= '0;
        misalign_err <= bad_req;
        timeout_err  <= 1'b0;
      end
      if (in_req) begin
        if (cnt != CNT_W'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
        if (mem.mem_ack && !we_p1) dmu_out_data <= ld_w;
        if (timeout_hit) timeout_err <= 1'b1;
      end
    end
  end

  dmu_lane_align #(
    .WIDTH (WIDTH),
    .OFF_W (OFF_W)
  ) u_align (
    .size      (f3_p1[1:0]),
    .offset    (addr_p1[OFF_W-1:0]),
    .uns       (f3_p1[2]),
    .st_data   (wdata_p1),
    .ld_data   (mem.mem_rdata),
    .be        (be_w),
    .wdata     (wdata_w),
    .ld_result (ld_w)
  );

  // Memory bus is quiet outside REQ so reset and idle show all zeros
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & we_p1;
  assign mem.mem_addr  = in_req ? {addr_p1[ADDR_WIDTH-1:OFF_W], OFF_W'(0)} : '0;
  assign mem.mem_be    = in_req ? be_w : '0;
  assign mem.mem_wdata = in_req ? wdata_w : '0;

  assign req_ready = (state == IDLE);
  assign dmu_done  = (state == RESP) || (state == ERR);
  assign stall     = (state == IDLE) ? (req_valid & (read_en | write_en)) : 1'b1;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit with one 32-bit and one 64-bit instance.
// A vector table drives single transactions; hand-written sequences cover
// ignored requests, timeout, ack-at-limit, late ack and reset mid-transaction.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;   // 0: 32-bit instance, 1: 64-bit instance
  logic        valid = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [63:0] wd = 64'd0;
  logic [63:0] rdata = 64'd0;
  logic        ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmu_mem_if #(.WIDTH(32), .ADDR_WIDTH(32)) m32();
  dmu_mem_if #(.WIDTH(64), .ADDR_WIDTH(32)) m64();

  assign m32.mem_ack   = ack & ~sel;
  assign m64.mem_ack   = ack & sel;
  assign m32.mem_rdata = rdata[31:0];
  assign m64.mem_rdata = rdata;

  logic        rdy32, done32, stall32, mis32, to32;
  logic        rdy64, done64, stall64, mis64, to64;
  logic [31:0] out32;
  logic [63:0] out64;

  data_mem_unit #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) u32 (
    .clk(clk), .rst(rst), .req_valid(valid & ~sel), .req_ready(rdy32),
    .read_en(rd), .write_en(wr), .Funct3(f3), .Mem_addr(addr),
    .RS2_data(wd[31:0]), .dmu_out_data(out32), .dmu_done(done32),
    .stall(stall32), .misalign_err(mis32), .timeout_err(to32), .mem(m32)
  );

  data_mem_unit #(.WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) u64 (
    .clk(clk), .rst(rst), .req_valid(valid & sel), .req_ready(rdy64),
    .read_en(rd), .write_en(wr), .Funct3(f3), .Mem_addr(addr),
    .RS2_data(wd), .dmu_out_data(out64), .dmu_done(done64),
    .stall(stall64), .misalign_err(mis64), .timeout_err(to64), .mem(m64)
  );

  // Observation mux onto the selected instance
  logic        o_req, o_we, o_done, o_mis, o_to, o_ready, o_stall;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  logic [63:0] o_wdata, o_out;
  assign o_req   = sel ? m64.mem_req   : m32.mem_req;
  assign o_we    = sel ? m64.mem_we    : m32.mem_we;
  assign o_addr  = sel ? m64.mem_addr  : m32.mem_addr;
  assign o_be    = sel ? m64.mem_be    : {4'h0, m32.mem_be};
  assign o_wdata = sel ? m64.mem_wdata : {32'h0, m32.mem_wdata};
  assign o_out   = sel ? out64 : {32'h0, out32};
  assign o_done  = sel ? done64  : done32;
  assign o_mis   = sel ? mis64   : mis32;
  assign o_to    = sel ? to64    : to32;
  assign o_ready = sel ? rdy64   : rdy32;
  assign o_stall = sel ? stall64 : stall32;

  typedef struct {
    bit          wide;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] rdata;
    bit          mis;
    logic [7:0]  be;
    logic [63:0] wexp;   // expected store data in enabled lanes
    logic [63:0] oexp;   // expected load result
  } vec_t;

  vec_t vt[$];
  logic [63:0] last32 = 64'd0;
  logic [63:0] last64 = 64'd0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit wide, input bit r, input bit w, input logic [2:0] fn,
                     input logic [31:0] a, input logic [63:0] d, input logic [63:0] rdv,
                     input bit m, input logic [7:0] b, input logic [63:0] we_x,
                     input logic [63:0] o_x);
    vec_t v;
    v.wide = wide; v.rd = r; v.wr = w; v.f3 = fn; v.addr = a; v.wd = d;
    v.rdata = rdv; v.mis = m; v.be = b; v.wexp = we_x; v.oexp = o_x;
    vt.push_back(v);
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] b);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic issue(input bit s, input bit r, input bit w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    sel = s; valid = 1'b1; rd = r; wr = w; f3 = fn; addr = a; wd = d;
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0] last;
    logic [31:0] aexp;
    last = v.wide ? last64 : last32;
    aexp = v.wide ? (v.addr & ~32'h7) : (v.addr & ~32'h3);
    issue(v.wide, v.rd, v.wr, v.f3, v.addr, v.wd);
    check($sformatf("v%0d stall_on_req", idx), {63'd0, o_stall}, 64'd1);
    @(negedge clk);
    valid = 1'b0; rd = 1'b0; wr = 1'b0;
    #1;
    if (v.mis) begin
      check($sformatf("v%0d err_no_req", idx), {63'd0, o_req}, 64'd0);
      check($sformatf("v%0d err_done", idx), {63'd0, o_done}, 64'd1);
      check($sformatf("v%0d misalign_err", idx), {63'd0, o_mis}, 64'd1);
      check($sformatf("v%0d err_out_hold", idx), o_out, last);
    end else begin
      check($sformatf("v%0d mem_req", idx), {63'd0, o_req}, 64'd1);
      check($sformatf("v%0d mem_we", idx), {63'd0, o_we}, {63'd0, v.wr});
      check($sformatf("v%0d mem_addr", idx), {32'd0, o_addr}, {32'd0, aexp});
      check($sformatf("v%0d mem_be", idx), {56'd0, o_be}, {56'd0, v.be});
      if (v.wr)
        check($sformatf("v%0d mem_wdata", idx), o_wdata & lane_mask(v.be), v.wexp);
      check($sformatf("v%0d no_early_done", idx), {63'd0, o_done}, 64'd0);
      check($sformatf("v%0d mis_cleared", idx), {63'd0, o_mis}, 64'd0);
      rdata = v.rdata; ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      #1;
      if (v.rd) last = v.oexp;
      check($sformatf("v%0d done", idx), {63'd0, o_done}, 64'd1);
      check($sformatf("v%0d out_data", idx), o_out, last);
      check($sformatf("v%0d req_dropped", idx), {63'd0, o_req}, 64'd0);
    end
    @(negedge clk);
    #1;
    check($sformatf("v%0d done_pulse_end", idx), {63'd0, o_done}, 64'd0);
    check($sformatf("v%0d back_idle", idx), {63'd0, o_ready}, 64'd1);
    if (v.wide) last64 = last; else last32 = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  reqc;
    bit  got;

    // Reset state
    #12;
    check("rst ready", {63'd0, rdy32}, 64'd1);
    check("rst mem_req", {63'd0, m32.mem_req}, 64'd0);
    check("rst mem_be", {60'd0, m32.mem_be}, 64'd0);
    check("rst done/stall/err", {60'd0, done32, stall32, mis32, to32}, 64'd0);
    check("rst out64", out64, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Ignored requests: both enables, then neither
    issue(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 64'd0);
    check("both_en stall", {63'd0, o_stall}, 64'd1);
    @(negedge clk); valid = 1'b0; rd = 1'b0; wr = 1'b0; #1;
    check("both_en ignored", {61'd0, o_ready, o_req, o_done}, 64'b100);
    issue(1'b0, 1'b0, 1'b0, 3'b010, 32'h10, 64'd0);
    check("no_en stall", {63'd0, o_stall}, 64'd0);
    @(negedge clk); valid = 1'b0; #1;
    check("no_en ignored", {61'd0, o_ready, o_req, o_done}, 64'b100);

    // 32-bit vectors
    add(0,1,0,3'b000,32'h3,   64'h0,        64'h80FF1234, 0,8'h08,64'h0,        64'hFFFFFF80);
    add(0,0,1,3'b001,32'h2,   64'h0000ABCD, 64'h0,        0,8'h0C,64'hABCD0000, 64'h0);
    add(0,1,0,3'b101,32'h2,   64'h0,        64'hABCD0000, 0,8'h0C,64'h0,        64'h0000ABCD);
    add(0,1,0,3'b001,32'h2,   64'h0,        64'hABCD0000, 0,8'h0C,64'h0,        64'hFFFFABCD);
    add(0,1,0,3'b010,32'h10,  64'h0,        64'h12345678, 0,8'h0F,64'h0,        64'h12345678);
    add(0,1,0,3'b100,32'h1,   64'h0,        64'h00009A00, 0,8'h02,64'h0,        64'h0000009A);
    add(0,0,1,3'b000,32'h21,  64'hFFFFFF5A, 64'h0,        0,8'h02,64'h00005A00, 64'h0);
    add(0,0,1,3'b010,32'h104, 64'hDEADBEEF, 64'h0,        0,8'h0F,64'hDEADBEEF, 64'h0);
    add(0,1,0,3'b010,32'h6,   64'h0,        64'h0,        1,8'h00,64'h0,        64'h0);
    add(0,1,0,3'b001,32'h1,   64'h0,        64'h0,        1,8'h00,64'h0,        64'h0);
    add(0,1,0,3'b000,32'h7,   64'h0,        64'h7F000000, 0,8'h08,64'h0,        64'h0000007F);
    add(0,1,0,3'b011,32'h0,   64'h0,        64'h0,        1,8'h00,64'h0,        64'h0);
    add(0,0,1,3'b100,32'h0,   64'h11,       64'h0,        1,8'h00,64'h0,        64'h0);
    add(0,1,0,3'b001,32'h2,   64'h0,        64'h80000000, 0,8'h0C,64'h0,        64'hFFFF8000);
    add(0,1,0,3'b110,32'h0,   64'h0,        64'h80000000, 0,8'h0F,64'h0,        64'h80000000);
    // 64-bit vectors
    add(1,1,0,3'b011,32'h8,   64'h0,        64'h0123456789ABCDEF, 0,8'hFF,64'h0, 64'h0123456789ABCDEF);
    add(1,1,0,3'b010,32'hC,   64'h0,        64'h8000000112345678, 0,8'hF0,64'h0, 64'hFFFFFFFF80000001);
    add(1,1,0,3'b110,32'hC,   64'h0,        64'h8000000112345678, 0,8'hF0,64'h0, 64'h0000000080000001);
    add(1,0,1,3'b010,32'h4,   64'hCAFEF00D, 64'h0,        0,8'hF0,64'hCAFEF00D00000000, 64'h0);
    add(1,1,0,3'b011,32'h4,   64'h0,        64'h0,        1,8'h00,64'h0,        64'h0);
    add(1,1,0,3'b001,32'h6,   64'h0,        64'h8001000000000000, 0,8'hC0,64'h0, 64'hFFFFFFFFFFFF8001);
    add(1,1,0,3'b100,32'h5,   64'h0,        64'h0000AA0000000000, 0,8'h20,64'h0, 64'h00000000000000AA);

    foreach (vt[i]) run_vec(i, vt[i]);

    // Timeout: no ack, 16 REQ cycles then ERR with timeout_err
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 64'd0);
    @(negedge clk); valid = 1'b0; rd = 1'b0; #1;
    reqc = 0; got = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_done) begin got = 1; break; end
      if (o_req) reqc++;
      @(negedge clk); #1;
    end
    check("timeout done seen", {63'd0, got}, 64'd1);
    check("timeout req cycles", 64'(reqc), 64'd16);
    check("timeout_err", {63'd0, o_to}, 64'd1);
    check("timeout req low", {63'd0, o_req}, 64'd0);
    check("timeout out hold", o_out, last32);
    // Late ack in IDLE is ignored
    @(negedge clk); ack = 1'b1; rdata = 64'hFFFF_FFFF;
    @(negedge clk); ack = 1'b0; #1;
    check("late ack no done", {63'd0, o_done}, 64'd0);
    check("late ack idle", {62'd0, o_ready, o_req}, 64'b10);
    check("late ack out", o_out, last32);
    check("timeout sticky", {63'd0, o_to}, 64'd1);

    // Ack in the final allowed cycle beats the timeout
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h44, 64'd0);
    @(negedge clk); valid = 1'b0; rd = 1'b0; #1;
    check("limit timeout cleared", {63'd0, o_to}, 64'd0);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk); #1;
    end
    check("limit still req", {62'd0, o_req, o_done}, 64'b10);
    rdata = 64'h5A5AC3C3; ack = 1'b1;
    @(negedge clk); ack = 1'b0; #1;
    check("limit ack done", {63'd0, o_done}, 64'd1);
    check("limit ack no timeout", {63'd0, o_to}, 64'd0);
    check("limit ack data", o_out, 64'h5A5AC3C3);

    // Reset while in REQ
    @(negedge clk);
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 64'd0);
    @(negedge clk); valid = 1'b0; rd = 1'b0; #1;
    check("rst_mid in req", {63'd0, o_req}, 64'd1);
    rst = 1'b0; #1;
    check("rst_mid req drop", {63'd0, o_req}, 64'd0);
    check("rst_mid ready", {63'd0, o_ready}, 64'd1);
    check("rst_mid no done", {63'd0, o_done}, 64'd0);
    check("rst_mid out32", o_out, 64'd0);
    check("rst_mid out64", out64, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst no done", {62'd0, o_done, o_req}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
